// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t   : controller FSM state (RUN, MC_WAIT)
//   XZR       : zero register number, never a real data dependence
//   ctrl_t    : bundle of the per-cycle stall/flush/pulse controls
//   load_use(): load-use dependence test between execute and decode
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic stall_F;
        logic stall_D;
        logic stall_E;
        logic flush_D;
        logic flush_E;
        logic flush_M;
        logic mcStart;
        logic mcAbort;
    } ctrl_t;

    // A load in execute whose destination feeds either decode source.
    // Writes to XZR are discarded, so they never form a dependence.
    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2);
        return mem_read && (rd != XZR) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   i_en  : increment enable for this cycle
//   o_cnt : current count, holds at all-ones once reached
module sat_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {CW{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flushes, load-use stalls and the
// handshake with a multi-cycle execute unit, plus two saturating
// performance counters.
//   clk, reset        : clock, asynchronous active-low reset
//   rs1_D, rs2_D      : decode source registers
//   rd_E, memRead_E   : execute destination / execute is a load
//   mcReq_E, mcDone   : multi-cycle request from execute / unit result valid
//   branchTaken_M     : taken branch resolved in memory stage
//   stall_*, flush_*  : pipeline register hold / bubble controls
//   mcStart, mcAbort  : single-cycle pulses to the multi-cycle unit
//   mcTimeout         : sticky flag, the unit overran TMO wait cycles
//   stallCount        : cycles with stall_F asserted (saturating)
//   flushCount        : cycles with a branch flush (saturating)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CW  = 32,
    parameter int TMO = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    rs1_D,
    input  logic [4:0]    rs2_D,
    input  logic [4:0]    rd_E,
    input  logic          memRead_E,
    input  logic          mcReq_E,
    input  logic          mcDone,
    input  logic          branchTaken_M,
    output logic          stall_F,
    output logic          stall_D,
    output logic          stall_E,
    output logic          flush_D,
    output logic          flush_E,
    output logic          flush_M,
    output logic          mcStart,
    output logic          mcAbort,
    output logic          mcTimeout,
    output logic [CW-1:0] stallCount,
    output logic [CW-1:0] flushCount
);

    // Timer must be able to hold TMO itself.
    localparam int            TW    = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_V = TW'(TMO);

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_timeout;

    state_t        w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_timeout_set;
    logic          w_branch_flush;
    ctrl_t         w_ctrl;

    // Decisions are evaluated in priority order: branch, then the
    // multi-cycle wait (timeout before normal waiting), then load-use.
    always_comb begin
        w_ctrl         = '0;
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_timeout_set  = 1'b0;
        w_branch_flush = 1'b0;

        if (branchTaken_M) begin
            // Wrong-path instructions in D and E are squashed. A pending or
            // just-requested multi-cycle op belongs to the wrong path too.
            w_branch_flush = 1'b1;
            w_ctrl.flush_D = 1'b1;
            w_ctrl.flush_E = 1'b1;
            w_ctrl.mcAbort = (r_state == MC_WAIT) || mcReq_E;
            w_state_nxt    = RUN;
            w_timer_nxt    = '0;
        end else if (r_state == MC_WAIT) begin
            if (mcDone) begin
                // Result is ready: let execute advance this very cycle.
                w_state_nxt = RUN;
                w_timer_nxt = '0;
            end else if (r_timer == TMO_V) begin
                // Give up: kill the op, replace it with a bubble and hold
                // the front end one cycle while the bubble moves on.
                w_ctrl.mcAbort = 1'b1;
                w_ctrl.flush_E = 1'b1;
                w_ctrl.stall_F = 1'b1;
                w_ctrl.stall_D = 1'b1;
                w_timeout_set  = 1'b1;
                w_state_nxt    = RUN;
                w_timer_nxt    = '0;
            end else begin
                w_ctrl.stall_F = 1'b1;
                w_ctrl.stall_D = 1'b1;
                w_ctrl.stall_E = 1'b1;
                w_ctrl.flush_M = 1'b1;
                w_timer_nxt    = r_timer + 1'b1;
            end
        end else if (mcReq_E) begin
            // mcDone is not looked at here; a result is only accepted once
            // the controller is actually waiting for it.
            w_ctrl.mcStart = 1'b1;
            w_ctrl.stall_F = 1'b1;
            w_ctrl.stall_D = 1'b1;
            w_ctrl.stall_E = 1'b1;
            w_ctrl.flush_M = 1'b1;
            w_state_nxt    = MC_WAIT;
            w_timer_nxt    = TW'(1);
        end else if (load_use(memRead_E, rd_E, rs1_D, rs2_D)) begin
            w_ctrl.stall_F = 1'b1;
            w_ctrl.stall_D = 1'b1;
            w_ctrl.flush_E = 1'b1;
        end

        // Held reset silences every control immediately, including the
        // abort that would otherwise accompany an abandoned operation.
        if (!reset) begin
            w_ctrl         = '0;
            w_branch_flush = 1'b0;
            w_timeout_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= RUN;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_timeout <= r_timeout | w_timeout_set;
        end
    end

    sat_counter #(.CW(CW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_ctrl.stall_F),
        .o_cnt (stallCount)
    );

    sat_counter #(.CW(CW)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (w_branch_flush),
        .o_cnt (flushCount)
    );

    assign stall_F   = w_ctrl.stall_F;
    assign stall_D   = w_ctrl.stall_D;
    assign stall_E   = w_ctrl.stall_E;
    assign flush_D   = w_ctrl.flush_D;
    assign flush_E   = w_ctrl.flush_E;
    assign flush_M   = w_ctrl.flush_M;
    assign mcStart   = w_ctrl.mcStart;
    assign mcAbort   = w_ctrl.mcAbort;
    assign mcTimeout = r_timeout;

endmodule
